// File: rtl/mem_cache_pkg.sv
// Shared constants, FSM state type and address field extraction for the MEM-stage data cache.
package mem_cache_pkg;

    localparam int unsigned SETS     = 64;
    localparam int unsigned TAG_W    = 10;
    localparam int unsigned MEM_BASE = 1024;
    localparam int unsigned IDX_W    = $clog2(SETS);
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned LINE_W   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic             word_sel;
    } addr_fields_t;

    // Rebase the byte address onto data memory, then slice word select, index and tag.
    function automatic addr_fields_t split_addr(input logic [31:0] byte_addr);
        logic [31:0]  a;
        addr_fields_t f;
        a          = byte_addr - 32'(MEM_BASE);
        f.word_sel = a[2];
        f.idx      = a[IDX_W+2:3];
        f.tag      = a[IDX_W+TAG_W+2:IDX_W+3];
        return f;
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line, input logic sel);
        return sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/mem_stage_cache_if.sv
// SRAM-controller side bus of the MEM-stage cache: line reads, word writes, single-cycle done pulse.
interface mem_stage_cache_if;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    modport master (
        output sram_r_en, sram_w_en, sram_addr, sram_wdata,
        input  sram_rdata, sram_ready
    );

    modport slave (
        input  sram_r_en, sram_w_en, sram_addr, sram_wdata,
        output sram_rdata, sram_ready
    );
endinterface

// File: rtl/cache_way.sv
// One way of the data cache: per-set valid bit, tag and 64-bit line, with fill and word-write ports.
module cache_way
    import mem_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    output logic              hit,
    output logic [LINE_W-1:0] line,
    input  logic              fill_en,
    input  logic [LINE_W-1:0] fill_line,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [WORD_W-1:0] wr_data
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];

    assign hit  = valid[idx] && (tag_mem[idx] == tag);
    assign line = data_mem[idx];

    // Only the valid bits need clearing; stale tags/data are masked by valid=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= fill_line;
        end else if (wr_en) begin
            if (wr_sel) data_mem[idx][LINE_W-1:WORD_W] <= wr_data;
            else        data_mem[idx][WORD_W-1:0]      <= wr_data;
        end
    end

endmodule

// File: rtl/mem_stage_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache for the MEM stage.
// Optional build macro CACHE_STATS_EN adds hit_cnt/miss_cnt counter outputs.
module mem_stage_cache
    import mem_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    output logic [31:0] out,
    output logic        ready,
    mem_stage_cache_if.master sram
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    state_t            state, state_d;
    addr_fields_t      f;
    logic [SETS-1:0]   lru;
    logic              hit0, hit1, hit_any, victim;
    logic [LINE_W-1:0] line0, line1, hit_line;
    logic              fill_en, wr_en, lru_upd, lru_val;
    logic              hit_inc, miss_inc;
    logic              r_en_q, w_en_q;
    logic [31:0]       addr_q, wdata_q;

    assign f        = split_addr(ALU_Res);
    assign hit_any  = hit0 | hit1;
    assign hit_line = hit0 ? line0 : line1;
    assign victim   = lru[f.idx];

    cache_way u_way0 (
        .clk(clk), .rst(rst), .idx(f.idx), .tag(f.tag), .hit(hit0), .line(line0),
        .fill_en(fill_en & ~victim), .fill_line(sram.sram_rdata),
        .wr_en(wr_en & hit0), .wr_sel(f.word_sel), .wr_data(Val_Rm)
    );

    cache_way u_way1 (
        .clk(clk), .rst(rst), .idx(f.idx), .tag(f.tag), .hit(hit1), .line(line1),
        .fill_en(fill_en & victim), .fill_line(sram.sram_rdata),
        .wr_en(wr_en & ~hit0 & hit1), .wr_sel(f.word_sel), .wr_data(Val_Rm)
    );

    // Next state plus the same-cycle ready/out handshake; way0 wins if both ways hit.
    always_comb begin
        state_d  = state;
        ready    = 1'b1;
        out      = '0;
        fill_en  = 1'b0;
        wr_en    = 1'b0;
        lru_upd  = 1'b0;
        lru_val  = victim;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready   = 1'b0;
                    state_d = WRITE;
                end else if (MEM_R_EN) begin
                    if (hit_any) begin
                        out     = line_word(hit_line, f.word_sel);
                        lru_upd = 1'b1;
                        lru_val = hit0;
                        hit_inc = 1'b1;
                    end else begin
                        ready    = 1'b0;
                        state_d  = RMISS;
                        miss_inc = 1'b1;
                    end
                end
            end
            RMISS: begin
                ready = sram.sram_ready;
                if (sram.sram_ready) begin
                    out     = line_word(sram.sram_rdata, f.word_sel);
                    fill_en = 1'b1;
                    lru_upd = 1'b1;
                    lru_val = ~victim;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                ready = sram.sram_ready;
                if (sram.sram_ready) begin
                    state_d = IDLE;
                    if (hit_any) begin
                        wr_en   = 1'b1;
                        lru_upd = 1'b1;
                        lru_val = hit0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // An aborted access must not leave the pipeline frozen while reset is held.
        if (!rst) begin
            ready = 1'b1;
            out   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            r_en_q  <= 1'b0;
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lru     <= '0;
        end else begin
            state  <= state_d;
            r_en_q <= (state_d == RMISS);
            w_en_q <= (state_d == WRITE);
            if (state == IDLE) begin
                addr_q  <= MEM_W_EN ? {ALU_Res[31:2], 2'b00} : {ALU_Res[31:3], 3'b000};
                wdata_q <= Val_Rm;
            end
            if (lru_upd) lru[f.idx] <= lru_val;
        end
    end

    assign sram.sram_r_en  = r_en_q;
    assign sram.sram_w_en  = w_en_q;
    assign sram.sram_addr  = addr_q;
    assign sram.sram_wdata = wdata_q;

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_inc) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_mem_stage_cache.sv
// Directed self-checking bench for mem_stage_cache: misses, hits, LRU eviction, writes, reset abort.
module tb_mem_stage_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_res, val_rm, out;
    logic        ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    int tests = 0;
    int fails = 0;

    mem_stage_cache_if sram_bus();

    mem_stage_cache dut (
        .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .ALU_Res(alu_res), .Val_Rm(val_rm), .out(out), .ready(ready), .sram(sram_bus)
`ifdef CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Read that is expected to miss: request, one RMISS cycle, then the sram_ready pulse.
    task automatic read_miss(input logic [31:0] addr, input logic [63:0] rdata,
                             output logic rdy0, output logic ren, output logic [31:0] raddr,
                             output logic rdy1, output logic [31:0] o);
        @(negedge clk); mem_r_en = 1'b1; alu_res = addr;
        #1 rdy0 = ready;
        @(negedge clk); ren = sram_bus.sram_r_en; raddr = sram_bus.sram_addr;
        sram_bus.sram_rdata = rdata; sram_bus.sram_ready = 1'b1;
        #1 rdy1 = ready; o = out;
        @(negedge clk); sram_bus.sram_ready = 1'b0; mem_r_en = 1'b0;
    endtask

    // Read that is expected to hit; ren is sram_r_en one cycle later.
    task automatic hit_read(input logic [31:0] addr, output logic rdy, output logic [31:0] o,
                            output logic ren);
        @(negedge clk); mem_r_en = 1'b1; alu_res = addr;
        #1 rdy = ready; o = out;
        @(negedge clk); mem_r_en = 1'b0; ren = sram_bus.sram_r_en;
    endtask

    task automatic write_req(input logic [31:0] addr, input logic [31:0] data, input logic also_rd,
                             output logic rdy0, output logic wen, output logic ren,
                             output logic [31:0] waddr, output logic [31:0] wdata, output logic rdy1);
        @(negedge clk); mem_w_en = 1'b1; mem_r_en = also_rd; alu_res = addr; val_rm = data;
        #1 rdy0 = ready;
        @(negedge clk); wen = sram_bus.sram_w_en; ren = sram_bus.sram_r_en;
        waddr = sram_bus.sram_addr; wdata = sram_bus.sram_wdata; sram_bus.sram_ready = 1'b1;
        #1 rdy1 = ready;
        @(negedge clk); sram_bus.sram_ready = 1'b0; mem_w_en = 1'b0; mem_r_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (out !== 32'h0) begin fails++; $display("FAIL reset_out got %h want 0", out); end
        tests++; if (sram_bus.sram_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en got %b want 0", sram_bus.sram_r_en); end
        tests++; if (sram_bus.sram_w_en !== 1'b0) begin fails++; $display("FAIL reset_w_en got %b want 0", sram_bus.sram_w_en); end
        @(negedge clk); rst = 1'b1;
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL idle_ready got %b want 1", ready); end
    endtask

    task automatic test_cold_read();
        logic r0, re, r1; logic [31:0] ra, o;
        read_miss(32'h400, 64'h0000BBBB_0000AAAA, r0, re, ra, r1, o);
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL cold_ready0 got %b want 0", r0); end
        tests++; if (re !== 1'b1) begin fails++; $display("FAIL cold_r_en got %b want 1", re); end
        tests++; if (ra !== 32'h400) begin fails++; $display("FAIL cold_addr got %h want 400", ra); end
        tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL cold_ready1 got %b want 1", r1); end
        tests++; if (o !== 32'hAAAA) begin fails++; $display("FAIL cold_out got %h want aaaa", o); end
        #1;
        tests++; if (sram_bus.sram_r_en !== 1'b0) begin fails++; $display("FAIL cold_r_en_drop got %b want 0", sram_bus.sram_r_en); end
`ifdef CACHE_STATS_EN
        tests++; if (miss_cnt !== 32'd1) begin fails++; $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt); end
`endif
    endtask

    task automatic test_hit();
        logic r, re; logic [31:0] o;
        hit_read(32'h404, r, o, re);
        tests++; if (r !== 1'b1) begin fails++; $display("FAIL hit_ready got %b want 1", r); end
        tests++; if (o !== 32'hBBBB) begin fails++; $display("FAIL hit_out got %h want bbbb", o); end
        tests++; if (re !== 1'b0) begin fails++; $display("FAIL hit_r_en got %b want 0", re); end
`ifdef CACHE_STATS_EN
        tests++; if (hit_cnt !== 32'd1) begin fails++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
`endif
    endtask

    // Index 0: 0x400 in way0, fill 0x600 then 0x800; 0x800 evicts 0x400.
    task automatic test_eviction();
        logic r0, re, r1, r; logic [31:0] ra, o;
        read_miss(32'h600, 64'h00002222_00001111, r0, re, ra, r1, o);
        tests++; if (o !== 32'h1111) begin fails++; $display("FAIL evict_600 got %h want 1111", o); end
        read_miss(32'h804, 64'h00004444_00003333, r0, re, ra, r1, o);
        tests++; if (ra !== 32'h800) begin fails++; $display("FAIL evict_804_addr got %h want 800", ra); end
        tests++; if (o !== 32'h4444) begin fails++; $display("FAIL evict_804 got %h want 4444", o); end
        hit_read(32'h600, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'h1111) begin fails++; $display("FAIL evict_600_hit got %b/%h want 1/1111", r, o); end
        read_miss(32'h400, 64'h0000BBBB_0000AAAA, r0, re, ra, r1, o);
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL evict_400_miss ready got %b want 0", r0); end
        tests++; if (o !== 32'hAAAA) begin fails++; $display("FAIL evict_400 got %h want aaaa", o); end
        hit_read(32'h600, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'h1111) begin fails++; $display("FAIL lru_keeps_600 got %b/%h want 1/1111", r, o); end
    endtask

    task automatic test_write_hit();
        logic r0, we, re, r1, r; logic [31:0] wa, wd, o;
        write_req(32'h400, 32'h1234, 1'b0, r0, we, re, wa, wd, r1);
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL wr_ready0 got %b want 0", r0); end
        tests++; if (we !== 1'b1 || re !== 1'b0) begin fails++; $display("FAIL wr_en got w%b r%b want w1 r0", we, re); end
        tests++; if (wa !== 32'h400 || wd !== 32'h1234) begin fails++; $display("FAIL wr_bus got %h/%h want 400/1234", wa, wd); end
        tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL wr_ready1 got %b want 1", r1); end
        hit_read(32'h400, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'h1234) begin fails++; $display("FAIL wr_hit_400 got %b/%h want 1/1234", r, o); end
        hit_read(32'h404, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'hBBBB) begin fails++; $display("FAIL wr_hit_404 got %b/%h want 1/bbbb", r, o); end
    endtask

    task automatic test_write_miss();
        logic r0, we, re, r1, r; logic [31:0] wa, wd, o, ra;
        write_req(32'hA00, 32'h5555, 1'b0, r0, we, re, wa, wd, r1);
        tests++; if (we !== 1'b1 || wa !== 32'hA00) begin fails++; $display("FAIL wmiss_bus got %b/%h want 1/a00", we, wa); end
        tests++; if (r1 !== 1'b1) begin fails++; $display("FAIL wmiss_ready1 got %b want 1", r1); end
        read_miss(32'hA00, 64'h00006666_00007777, r0, re, ra, r1, o);
        tests++; if (r0 !== 1'b0 || re !== 1'b1) begin fails++; $display("FAIL no_alloc got ready%b r_en%b want 0/1", r0, re); end
        tests++; if (o !== 32'h7777) begin fails++; $display("FAIL wmiss_read got %h want 7777", o); end
        hit_read(32'h400, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'h1234) begin fails++; $display("FAIL wmiss_400 got %b/%h want 1/1234", r, o); end
    endtask

    task automatic test_priority();
        logic r0, we, re, r1, r; logic [31:0] wa, wd, o;
        write_req(32'h404, 32'hCAFE, 1'b1, r0, we, re, wa, wd, r1);
        tests++; if (r0 !== 1'b0) begin fails++; $display("FAIL prio_ready0 got %b want 0", r0); end
        tests++; if (we !== 1'b1 || re !== 1'b0) begin fails++; $display("FAIL prio_en got w%b r%b want w1 r0", we, re); end
        hit_read(32'h404, r, o, re);
        tests++; if (r !== 1'b1 || o !== 32'hCAFE) begin fails++; $display("FAIL prio_404 got %b/%h want 1/cafe", r, o); end
    endtask

    task automatic test_reset_mid();
        logic r0, re, r1; logic [31:0] ra, o;
        @(negedge clk); mem_r_en = 1'b1; alu_res = 32'hE08;
        @(negedge clk);
        tests++; if (sram_bus.sram_r_en !== 1'b1) begin fails++; $display("FAIL rmid_r_en got %b want 1", sram_bus.sram_r_en); end
        #2 rst = 1'b0;
        #1;
        tests++; if (sram_bus.sram_r_en !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL rmid_abort got r_en%b ready%b want 0/1", sram_bus.sram_r_en, ready); end
        tests++; if (out !== 32'h0) begin fails++; $display("FAIL rmid_out got %h want 0", out); end
        @(negedge clk); rst = 1'b1;
        #1;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rmid_remiss got %b want 0", ready); end
        @(negedge clk);
        tests++; if (sram_bus.sram_r_en !== 1'b1) begin fails++; $display("FAIL rmid_r_en2 got %b want 1", sram_bus.sram_r_en); end
        sram_bus.sram_rdata = 64'h00009999_00008888; sram_bus.sram_ready = 1'b1;
        #1;
        tests++; if (ready !== 1'b1 || out !== 32'h8888) begin fails++; $display("FAIL rmid_fill got %b/%h want 1/8888", ready, out); end
        @(negedge clk); sram_bus.sram_ready = 1'b0; mem_r_en = 1'b0;
`ifdef CACHE_STATS_EN
        tests++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin fails++; $display("FAIL rmid_stats got %0d/%0d want 1/0", miss_cnt, hit_cnt); end
`endif
        read_miss(32'h400, 64'h0000BBBB_0000AAAA, r0, re, ra, r1, o);
        tests++; if (r0 !== 1'b0 || o !== 32'hAAAA) begin fails++; $display("FAIL rmid_cleared got %b/%h want 0/aaaa", r0, o); end
    endtask

    initial begin
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = '0; val_rm = '0;
        sram_bus.sram_rdata = '0; sram_bus.sram_ready = 1'b0;
        test_reset();
        test_cold_read();
        test_hit();
        test_eviction();
        test_write_hit();
        test_write_miss();
        test_priority();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
